// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file write-back controller.
//   wb_state_t : issue state machine encoding
//   wb_entry_t : one queued write request {rd, data}
//   ADDR_W_DFLT / DATA_W_DFLT : default register index / data widths
package regfile_wb_pkg;

   localparam int ADDR_W_DFLT = 5;
   localparam int DATA_W_DFLT = 32;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_RELEASE = 2'd2
   } wb_state_t;

   typedef struct packed {
      logic [ADDR_W_DFLT-1:0] rd;
      logic [DATA_W_DFLT-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries.
//   clk, rst (sync, active-low)
//   push, push_entry : enqueue (ignored when full)
//   pop              : dequeue head (ignored when empty)
//   full, empty      : occupancy status
//   head             : entry at the read pointer
//   entries/occupied : every storage slot plus a mask of the slots holding live data
module wb_fifo
   import regfile_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wb_entry_t              push_entry,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output wb_entry_t              head,
   output wb_entry_t [DEPTH-1:0]  entries,
   output logic      [DEPTH-1:0]  occupied
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   wb_entry_t [DEPTH-1:0] mem;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] count;
   logic [AW-1:0] offset;

   // The extra pointer MSB distinguishes full from empty when the indices match.
   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
   assign head  = mem[rptr[AW-1:0]];
   assign entries = mem;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) wptr <= wptr + PW'(1);
         if (pop && !empty) rptr <= rptr + PW'(1);
      end
   end

   // Storage is not reset; only slots flagged in 'occupied' are ever consumed.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wptr[AW-1:0]] <= push_entry;
   end

   // A slot is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      occupied = '0;
      offset   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset      = AW'(i) - rptr[AW-1:0];
         occupied[i] = ({1'b0, offset} < count);
      end
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller in front of the register file write port.
//   clk, rst (sync, active-low)
//   in_valid/in_rd/in_data/in_ready : write request handshake from the datapath
//   write/rd/input_data             : registered write port to the register file
//   write_finish                    : register file acknowledge
//   rs/rt -> rs_pending/rt_pending  : hazard check against queued + in-flight writes
//   idle                            : nothing queued and no write outstanding
module regfile_wb_ctrl
   import regfile_wb_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = DATA_W_DFLT,
   parameter int ADDR_W = ADDR_W_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              write,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] input_data,
   input  logic              write_finish,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   output logic              rs_pending,
   output logic              rt_pending,
   output logic              idle
);

   wb_entry_t             push_entry;
   wb_entry_t             head;
   wb_entry_t [DEPTH-1:0] entries;
   logic      [DEPTH-1:0] occupied;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  rs_hit;
   logic                  rt_hit;

   wb_state_t             state;
   wb_state_t             state_nxt;
   logic                  write_nxt;
   logic [ADDR_W-1:0]     rd_nxt;
   logic [DATA_W-1:0]     data_nxt;

   // No bypass: a full queue refuses even when it pops this cycle.
   assign in_ready   = rst && !full;
   // Writes to $0 complete the handshake but are dropped.
   assign push       = in_valid && in_ready && (in_rd != '0);
   assign push_entry = '{rd: in_rd, data: in_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .full       (full),
      .empty      (empty),
      .head       (head),
      .entries    (entries),
      .occupied   (occupied)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         write      <= 1'b0;
         rd         <= '0;
         input_data <= '0;
      end else begin
         state      <= state_nxt;
         write      <= write_nxt;
         rd         <= rd_nxt;
         input_data <= data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      write_nxt = write;
      rd_nxt    = rd;
      data_nxt  = input_data;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               state_nxt = S_ISSUE;
               write_nxt = 1'b1;
               rd_nxt    = head.rd;
               data_nxt  = head.data;
            end
         end
         S_ISSUE: begin
            // The head stays queued (and visible to the hazard check) until acknowledged.
            if (write_finish) begin
               pop       = 1'b1;
               write_nxt = 1'b0;
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // Wait for the acknowledge to drop so one pulse never retires two writes.
            if (!write_finish) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            write_nxt = 1'b0;
         end
      endcase
   end

   always_comb begin
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occupied[i] && (entries[i].rd == rs)) rs_hit = 1'b1;
         if (occupied[i] && (entries[i].rd == rt)) rt_hit = 1'b1;
      end
   end

   assign rs_pending = rst && (rs != '0) && rs_hit;
   assign rt_pending = rst && (rt != '0) && rt_hit;
   assign idle       = !rst || (empty && (state == S_IDLE));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } req_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [4:0]  in_rd = '0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic        write;
   logic [4:0]  rd;
   logic [31:0] input_data;
   logic        write_finish = 1'b0;
   logic [4:0]  rs = '0;
   logic [4:0]  rt = '0;
   logic        rs_pending;
   logic        rt_pending;
   logic        idle;

   // Reference model: outstanding requests (queued or in flight), in acceptance order.
   req_t mq[$];
   // Scoreboard: writes the model expects the DUT to present, in issue order.
   req_t sb[$];
   bit   m_issued = 0;
   bit   m_rel = 0;

   int   n_checks = 0;
   int   n_fail = 0;

   bit   ack_en = 0;
   int   ack_delay = 0;
   int   ack_hold = 0;

   regfile_wb_ctrl #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_rd        (in_rd),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .write        (write),
      .rd           (rd),
      .input_data   (input_data),
      .write_finish (write_finish),
      .rs           (rs),
      .rt           (rt),
      .rs_pending   (rs_pending),
      .rt_pending   (rt_pending),
      .idle         (idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_pending(input logic [4:0] r);
      if (!rst || r == 5'd0) return 1'b0;
      foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
      return 1'b0;
   endfunction

   // Model update on each rising edge from pre-edge inputs.
   initial begin
      forever begin
         int sz;
         @(posedge clk);
         sz = mq.size();
         if (!rst) begin
            mq.delete();
            m_issued = 0;
            m_rel = 0;
         end else begin
            if (m_issued) begin
               if (write_finish) begin
                  void'(mq.pop_front());
                  m_issued = 0;
                  m_rel = 1;
               end
            end else if (m_rel) begin
               if (!write_finish) m_rel = 0;
            end else if (sz > 0) begin
               m_issued = 1;
               sb.push_back(mq[0]);
            end
            if (in_valid && sz < DEPTH && in_rd != 5'd0)
               mq.push_back('{rd: in_rd, data: in_data});
         end
      end
   end

   // Monitor: compare DUT outputs mid-cycle.
   initial begin
      bit   pw;
      req_t cur;
      pw = 0;
      cur = '{rd: 5'd0, data: 32'd0};
      forever begin
         @(negedge clk);
         check("in_ready", 32'(in_ready), 32'(rst && mq.size() < DEPTH));
         check("idle", 32'(idle), 32'(!rst || (mq.size() == 0 && !m_rel)));
         check("rs_pending", 32'(rs_pending), 32'(model_pending(rs)));
         check("rt_pending", 32'(rt_pending), 32'(model_pending(rt)));
         check("write", 32'(write), 32'(m_issued));
         if (write && !pw) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: rd=%0d data=%0h with no write expected", rd, input_data);
            end else begin
               cur = sb.pop_front();
            end
         end
         if (write) begin
            check("wr_rd", 32'(rd), 32'(cur.rd));
            check("wr_data", input_data, cur.data);
         end
         pw = write;
      end
   end

   // Register file acknowledge responder.
   initial begin
      int wcnt;
      int hcnt;
      wcnt = 0;
      hcnt = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!ack_en) begin
            write_finish = 1'b0;
            wcnt = 0;
            hcnt = 0;
         end else if (write_finish) begin
            if (hcnt == 0) write_finish = 1'b0;
            else hcnt--;
         end else if (write) begin
            if (wcnt >= ack_delay) begin
               write_finish = 1'b1;
               hcnt = ack_hold;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [4:0] r, input logic [31:0] d);
      int t;
      bit acc;
      t = 0;
      acc = 0;
      in_valid = 1'b1;
      in_rd = r;
      in_data = d;
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #2;
         t++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: rd=%0d not accepted, required acceptance within 200 cycles", r);
      end
   endtask

   task automatic wait_idle();
      int t;
      bit done;
      t = 0;
      done = 0;
      while (!done && t < 1000) begin
         @(negedge clk);
         done = idle && (sb.size() == 0) && (mq.size() == 0);
         t++;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL idle_timeout: idle=%0d after 1000 cycles, required 1", idle);
      end
      step(1);
   endtask

   initial begin
      // Reset
      step(3);
      @(negedge clk);
      check("rst_rd", 32'(rd), 32'd0);
      check("rst_data", input_data, 32'd0);
      check("rst_idle", 32'(idle), 32'd1);
      step(1);
      rst = 1'b1;
      step(2);

      // Basic write
      ack_en = 1; ack_delay = 2; ack_hold = 0;
      send(5'd5, 32'hDEADBEEF);
      @(posedge clk);
      @(negedge clk);
      check("basic_write", 32'(write), 32'd1);
      check("basic_rd", 32'(rd), 32'd5);
      check("basic_data", input_data, 32'hDEADBEEF);
      step(1);
      wait_idle();

      // $0 discard
      send(5'd0, 32'h1234);
      step(3);
      @(negedge clk);
      check("zero_nowrite", 32'(write), 32'd0);
      check("zero_idle", 32'(idle), 32'd1);
      step(1);

      // Full queue, fifth request held off until acknowledges flow
      ack_en = 0;
      for (int i = 1; i <= 4; i++) send(5'(i), 32'h100 + 32'(i));
      @(negedge clk);
      check("full_ready", 32'(in_ready), 32'd0);
      step(1);
      fork
         send(5'd20, 32'h555);
         begin
            step(6);
            ack_en = 1; ack_delay = 0; ack_hold = 0;
         end
      join
      wait_idle();

      // Pending flags
      ack_en = 0;
      rs = 5'd7; rt = 5'd9;
      send(5'd7, 32'h77);
      send(5'd9, 32'h99);
      @(negedge clk);
      check("pend_rs", 32'(rs_pending), 32'd1);
      check("pend_rt", 32'(rt_pending), 32'd1);
      step(1);
      ack_en = 1; ack_delay = 1; ack_hold = 0;
      begin
         int t;
         t = 0;
         while (rs_pending && t < 50) begin
            @(negedge clk);
            t++;
         end
         check("pend_rs_drop", 32'(rs_pending), 32'd0);
         check("pend_rt_keep", 32'(rt_pending), 32'd1);
      end
      step(1);
      wait_idle();
      rs = 5'd0;
      rt = 5'd0;

      // Acknowledge held high for several cycles
      ack_delay = 1; ack_hold = 3;
      send(5'd3, 32'hA3);
      send(5'd4, 32'hA4);
      wait_idle();

      // Reset while a write is in flight with two more queued
      ack_en = 0;
      rs = 5'd11; rt = 5'd12;
      send(5'd10, 32'hB0);
      send(5'd11, 32'hB1);
      send(5'd12, 32'hB2);
      @(negedge clk);
      check("mid_write_on", 32'(write), 32'd1);
      step(1);
      rst = 1'b0;
      step(1);
      @(negedge clk);
      check("mid_rst_write", 32'(write), 32'd0);
      check("mid_rst_idle", 32'(idle), 32'd1);
      step(1);
      rst = 1'b1;
      ack_en = 1; ack_delay = 0; ack_hold = 0;
      step(10);

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_rd = 5'($urandom_range(0, 7));
         in_data = $urandom;
         rs = 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         if (c % 25 == 0) begin
            ack_delay = $urandom_range(0, 3);
            ack_hold = $urandom_range(0, 3);
         end
         rst = (c == 200) ? 1'b0 : 1'b1;
         step(1);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      wait_idle();

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller that sits in front of the 32×32 register file's write port in the single-cycle CPU. It queues register write requests from the datapath, then issues them one at a time on the register file's `write`/`rd`/`input_data` port. Each write is retired only after the register file raises `write_finish`. It also reports, combinationally, whether a source register read (`rs`, `rt`) would hit a write that is still pending, so the decode logic can stall.

## Interface
Parameters:
- `DEPTH`, 4: write queue entries; must be a power of 2, at least 2.
- `DATA_W`, 32: register data width.
- `ADDR_W`, 5: register index width.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-low.
- `in_valid`: input, 1 bit. Write request present.
- `in_rd`: input, `ADDR_W` bits. Destination register of the request.
- `in_data`: input, `DATA_W` bits. Write data of the request.
- `in_ready`: output, 1 bit. Controller can accept a request this cycle.
- `write`: output, 1 bit. Write strobe to the register file.
- `rd`: output, `ADDR_W` bits. Register file write address.
- `input_data`: output, `DATA_W` bits. Register file write data.
- `write_finish`: input, 1 bit. Register file write acknowledge.
- `rs`, `rt`: input, `ADDR_W` bits each. Source register indices to check.
- `rs_pending`, `rt_pending`: output, 1 bit each. The matching source register has a queued or in-flight write.
- `idle`: output, 1 bit. Queue is empty and no write is outstanding.

## Operation
- **Accept.** A request is accepted on a rising edge when `in_valid && in_ready`. `in_ready = rst && !full`. There is no bypass, so a full queue refuses the request even in a cycle where it pops.
- **Register $0.** A request with `in_rd == 0` is accepted (handshake completes) but is discarded and never enqueued.
- **State machine**, states `S_IDLE`, `S_ISSUE`, `S_RELEASE`:
  - `S_IDLE`: if the queue is not empty, go to `S_ISSUE`. On the same edge, register `write<=1` and load `rd`/`input_data` from the queue head.
  - `S_ISSUE`: hold `write`, `rd` and `input_data` stable. On the first edge where `write_finish==1`, pop the head, set `write<=0` and go to `S_RELEASE`.
  - `S_RELEASE`: wait for `write_finish==0`, then go to `S_IDLE`. No new write is issued until the acknowledge has dropped.
- **Pending flags.** `rs_pending` is 1 when any occupied queue entry, including the in-flight head, has `rd == rs`, and `rs != 0`. `rt_pending` is defined the same way for `rt`. Both are purely combinational.
- **idle**: `idle = empty && state==S_IDLE`.
- **Reset values** (while `rst==0` at an edge): queue empty, read and write pointers 0, state `S_IDLE`, `write=0`, `rd=0`, `input_data=0`. While `rst==0`: `in_ready=0`, `rs_pending=0`, `rt_pending=0`, `idle=1`.
- **Reset mid-operation.** All queued entries are dropped and `write` falls on that edge. Any acknowledge still high afterwards is ignored until the next issue.
- **Pointers.** Pointers are `log2(DEPTH)+1` bits and wrap modulo `2*DEPTH`. The queue is full when the low bits are equal and the MSBs differ.

## Timing
- Minimum latency from acceptance to `write` high:
  - The request is accepted at edge t0.
  - The FSM sees a non-empty queue and, at edge t1, raises `write`.
- Minimum issue-to-issue spacing is 3 edges: ISSUE → RELEASE → IDLE → ISSUE. Throughput is bounded by the register file's acknowledge.
- `write`, `rd` and `input_data` are registered outputs. They never change while `write==1` and `write_finish==0`.
- Simultaneous accept and pop:
  - The occupancy count is unchanged.
  - A just-popped entry no longer drives the pending flags in the following cycle.

## Structure
- Package `regfile_wb_pkg` holds:
  - the state enum (`S_IDLE`, `S_ISSUE`, `S_RELEASE`);
  - the `ADDR_W` and `DATA_W` defaults;
  - the `wb_entry_t` struct `{rd, data}`.
- Sub-module `wb_fifo` is a synchronous FIFO of `wb_entry_t` with parameter `DEPTH`. It provides:
  - push and pop;
  - `full` and `empty`;
  - head output;
  - a flattened view of all occupied entries, used for the pending compare.
- The top level holds the FSM and the pending comparators.

## Test plan
- **Basic write.** After reset, push `(rd=5, data=0xDEADBEEF)`. Expect:
  - `write=1`, `rd=5`, `input_data=0xDEADBEEF` after edge t1;
  - with `write_finish` asserted 2 cycles later, `write` falls on that edge and `idle=1` after the acknowledge drops.
- **$0 discard.** Push `(rd=0, data=0x1234)`. Expect `in_ready` handshake completes, `write` never asserts, `idle` stays 1.
- **Full queue.** Hold `write_finish=0` and push 5 requests with `DEPTH=4`. Expect:
  - `in_ready=0` after 4 accepts;
  - the 5th request is held off;
  - after the acknowledges, the writes issue in order `rd=1,2,3,4`, then the 5th.
- **Pending flags.** Queue `rd=7` and `rd=9`. With `rs=7, rt=9`, expect `rs_pending=rt_pending=1`. After the `rd=7` write retires, expect `rs_pending=0`, `rt_pending=1`. With `rs=0`, expect `rs_pending=0` always.
- **Acknowledge held high.** Keep `write_finish=1` for 3 cycles after the first acknowledge. Expect the second write not to issue until `write_finish` returns to 0.
- **Reset mid-write.** Assert `rst=0` while `write=1` with 2 entries queued. Expect at the next edge:
  - `write=0` and `idle=1`;
  - both pending flags 0;
  - no further writes after reset is released.
